// File: rtl/memory_access_arbiter.sv
// Round-robin arbiter sharing one memory command bus between a writer (W) and two readers (A, B).
// One registered command per cycle; read valids are returned READ_LAT cycles after the strobe.
module memory_access_arbiter #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int MEM_DEPTH = 1024,
   parameter int READ_LAT  = 1
) (
   input  logic              Clock,
   input  logic              iReset_n,
   input  logic              iReqW,
   input  logic [ADDR_W-1:0] iAddrW,
   input  logic [DATA_W-1:0] iDataW,
   output logic              oAckW,
   input  logic              iReqA,
   input  logic [ADDR_W-1:0] iAddrA,
   output logic              oAckA,
   output logic              oValidA,
   output logic [DATA_W-1:0] oDataA,
   input  logic              iReqB,
   input  logic [ADDR_W-1:0] iAddrB,
   output logic              oAckB,
   output logic              oValidB,
   output logic [DATA_W-1:0] oDataB,
   output logic              oErr,
   output logic              oWriteEnable,
   output logic              oReadtoa,
   output logic              oReadtob,
   output logic [ADDR_W-1:0] oAddress,
   output logic [DATA_W-1:0] oDataIn,
   input  logic [DATA_W-1:0] iMemDataA,
   input  logic [DATA_W-1:0] iMemDataB
);

   typedef enum logic {IDLE, ISSUE} state_t;

   localparam logic [1:0] SEL_W = 2'd0;
   localparam logic [1:0] SEL_A = 2'd1;
   localparam logic [1:0] SEL_B = 2'd2;
   // A full power-of-two address space has no illegal addresses.
   localparam bit ERR_EN = (MEM_DEPTH < (1 << ADDR_W));

   state_t              state_q, state_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [1:0]          gnt_q, gnt_d;
   logic                ack_w_q, ack_w_d;
   logic                ack_a_q, ack_a_d;
   logic                ack_b_q, ack_b_d;
   logic                err_q, err_d;
   logic                we_q, we_d;
   logic                rda_q, rda_d;
   logic                rdb_q, rdb_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [READ_LAT-1:0] vld_a_q, vld_b_q;

   logic [2:0] busy;
   logic [2:0] elig;
   logic [1:0] cand0, cand1, cand2;
   logic [1:0] sel;
   logic       found;

   function automatic logic [1:0] next_sel(input logic [1:0] s);
      return (s == SEL_B) ? SEL_W : s + 2'd1;
   endfunction

   function automatic logic is_elig(input logic [2:0] e, input logic [1:0] s);
      case (s)
         SEL_W:   return e[0];
         SEL_A:   return e[1];
         SEL_B:   return e[2];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
      return ERR_EN && (32'(addr) >= 32'(MEM_DEPTH));
   endfunction

   always_comb begin
      // The requester on the bus this cycle is dropping its request at the next edge.
      busy    = (state_q == ISSUE) ? (3'b001 << gnt_q) : 3'b000;
      elig    = {iReqB, iReqA, iReqW} & ~busy;
      cand0   = ptr_q;
      cand1   = next_sel(cand0);
      cand2   = next_sel(cand1);
      found   = 1'b1;
      sel     = cand0;
      if (is_elig(elig, cand0))      sel = cand0;
      else if (is_elig(elig, cand1)) sel = cand1;
      else if (is_elig(elig, cand2)) sel = cand2;
      else                           found = 1'b0;

      state_d = IDLE;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      ack_w_d = 1'b0;
      ack_a_d = 1'b0;
      ack_b_d = 1'b0;
      err_d   = 1'b0;
      we_d    = 1'b0;
      rda_d   = 1'b0;
      rdb_d   = 1'b0;
      addr_d  = '0;
      din_d   = '0;
      if (found) begin
         state_d = ISSUE;
         gnt_d   = sel;
         ptr_d   = next_sel(sel);
         case (sel)
            SEL_W: begin
               ack_w_d = 1'b1;
               addr_d  = iAddrW;
               din_d   = iDataW;
            end
            SEL_A: begin
               ack_a_d = 1'b1;
               addr_d  = iAddrA;
            end
            default: begin
               ack_b_d = 1'b1;
               addr_d  = iAddrB;
            end
         endcase
         err_d = out_of_range(addr_d);
         we_d  = ack_w_d & ~err_d;
         rda_d = ack_a_d & ~err_d;
         rdb_d = ack_b_d & ~err_d;
      end
   end

   always_ff @(posedge Clock or negedge iReset_n) begin
      if (!iReset_n) begin
         state_q <= IDLE;
         ptr_q   <= SEL_W;
         gnt_q   <= SEL_W;
         ack_w_q <= 1'b0;
         ack_a_q <= 1'b0;
         ack_b_q <= 1'b0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         rda_q   <= 1'b0;
         rdb_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         vld_a_q <= '0;
         vld_b_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         ack_w_q <= ack_w_d;
         ack_a_q <= ack_a_d;
         ack_b_q <= ack_b_d;
         err_q   <= err_d;
         we_q    <= we_d;
         rda_q   <= rda_d;
         rdb_q   <= rdb_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         // Read-return delay lines: bit k set means a strobe k+1 cycles ago.
         vld_a_q <= (vld_a_q << 1) | READ_LAT'(rda_q);
         vld_b_q <= (vld_b_q << 1) | READ_LAT'(rdb_q);
      end
   end

   assign oAckW        = ack_w_q;
   assign oAckA        = ack_a_q;
   assign oAckB        = ack_b_q;
   assign oErr         = err_q;
   assign oWriteEnable = we_q;
   assign oReadtoa     = rda_q;
   assign oReadtob     = rdb_q;
   assign oAddress     = addr_q;
   assign oDataIn      = din_q;
   assign oValidA      = vld_a_q[READ_LAT-1];
   assign oValidB      = vld_b_q[READ_LAT-1];
   assign oDataA       = iMemDataA;
   assign oDataB       = iMemDataB;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Bench for memory_access_arbiter: directed scenarios plus random traffic against a
// transaction-level model (RR pointer, ack mask, memory array, read-return history).
module tb_memory_access_arbiter;
   localparam int DW    = 8;
   localparam int AW    = 10;
   localparam int DEPTH = 1000;
   localparam int RL    = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          reqW = 1'b0, reqA = 1'b0, reqB = 1'b0;
   logic [AW-1:0] addrW = '0, addrA = '0, addrB = '0;
   logic [DW-1:0] dataW = '0;
   logic          oAckW, oAckA, oAckB, oValidA, oValidB, oErr;
   logic          oWriteEnable, oReadtoa, oReadtob;
   logic [AW-1:0] oAddress;
   logic [DW-1:0] oDataIn, oDataA, oDataB, memA, memB;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   always #5 clk = ~clk;

   memory_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .READ_LAT(RL)) dut (
      .Clock(clk), .iReset_n(rst_n),
      .iReqW(reqW), .iAddrW(addrW), .iDataW(dataW), .oAckW(oAckW),
      .iReqA(reqA), .iAddrA(addrA), .oAckA(oAckA), .oValidA(oValidA), .oDataA(oDataA),
      .iReqB(reqB), .iAddrB(addrB), .oAckB(oAckB), .oValidB(oValidB), .oDataB(oDataB),
      .oErr(oErr), .oWriteEnable(oWriteEnable), .oReadtoa(oReadtoa), .oReadtob(oReadtob),
      .oAddress(oAddress), .oDataIn(oDataIn), .iMemDataA(memA), .iMemDataB(memB));

   // Memory device: write on strobe, read data delivered RL cycles after the read strobe.
   logic [DW-1:0] mem [1024];
   logic [DW-1:0] pa [RL];
   logic [DW-1:0] pb [RL];
   always @(posedge clk) begin
      if (oWriteEnable) mem[oAddress] <= oDataIn;
      pa[0] <= mem[oAddress];
      pb[0] <= mem[oAddress];
      for (int i = 1; i < RL; i++) begin
         pa[i] <= pa[i-1];
         pb[i] <= pb[i-1];
      end
   end
   assign memA = pa[RL-1];
   assign memB = pb[RL-1];

   // Reference model state
   int            m_ptr, m_last;
   logic [DW-1:0] m_mem [1024];
   bit            sA [RL+1];
   bit            sB [RL+1];
   logic [DW-1:0] dA [RL+1];
   logic [DW-1:0] dB [RL+1];
   bit            e_ackW, e_ackA, e_ackB, e_err, e_we, e_ra, e_rb, e_vA, e_vB;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_din, e_dA, e_dB;

   task automatic model_reset();
      m_ptr = 0;
      m_last = -1;
      for (int k = 0; k <= RL; k++) begin
         sA[k] = 0; sB[k] = 0; dA[k] = '0; dB[k] = '0;
      end
   endtask

   task automatic model_step();
      bit            rq [3];
      logic [AW-1:0] ad [3];
      int g, c;
      rq[0] = reqW; rq[1] = reqA; rq[2] = reqB;
      ad[0] = addrW; ad[1] = addrA; ad[2] = addrB;
      g = -1;
      for (int k = 0; k < 3; k++) begin
         c = (m_ptr + k) % 3;
         if (g < 0 && rq[c] && c != m_last) g = c;
      end
      {e_ackW, e_ackA, e_ackB, e_err, e_we, e_ra, e_rb} = '0;
      e_addr = '0;
      e_din  = '0;
      for (int k = RL; k > 0; k--) begin
         sA[k] = sA[k-1]; dA[k] = dA[k-1];
         sB[k] = sB[k-1]; dB[k] = dB[k-1];
      end
      sA[0] = 0; sB[0] = 0;
      m_last = g;
      if (g >= 0) begin
         m_ptr  = (g + 1) % 3;
         e_addr = ad[g];
         case (g)
            0: begin e_ackW = 1; e_din = dataW; end
            1: e_ackA = 1;
            default: e_ackB = 1;
         endcase
         if (int'(ad[g]) >= DEPTH) e_err = 1;
         else begin
            case (g)
               0: begin e_we = 1; m_mem[ad[g]] = dataW; end
               1: begin e_ra = 1; sA[0] = 1; dA[0] = m_mem[ad[g]]; end
               default: begin e_rb = 1; sB[0] = 1; dB[0] = m_mem[ad[g]]; end
            endcase
         end
      end
      e_vA = sA[RL]; e_dA = dA[RL];
      e_vB = sB[RL]; e_dB = dB[RL];
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reqW = 0; reqA = 0; reqB = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
   endtask

   task automatic idle(int n);
      reqW = 0; reqA = 0; reqB = 0;
      repeat (n) tick();
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 9) == 0) return AW'($urandom_range(990, 1023));
      return AW'($urandom_range(0, 15));
   endfunction

   task automatic test_reset();
      #2 rst_n = 0;
      #1;
      nvec++;
      if ({oAckW, oAckA, oAckB, oValidA, oValidB, oErr, oWriteEnable, oReadtoa, oReadtob, oAddress, oDataIn} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs: got %b, want all zero",
                  {oAckW, oAckA, oAckB, oValidA, oValidB, oErr, oWriteEnable, oReadtoa, oReadtob, oAddress, oDataIn});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
      tick();
      nvec++;
      if ({oAckW, oAckA, oAckB, oWriteEnable, oReadtoa, oReadtob} !== 6'b0) begin
         nerr++;
         $display("FAIL idle_after_reset: got %b, want 000000", {oAckW, oAckA, oAckB, oWriteEnable, oReadtoa, oReadtob});
      end
   endtask

   task automatic test_write_read();
      reqW = 1; addrW = 10'h005; dataW = 8'hA5;
      tick();
      nvec++;
      if ({oAckW, oWriteEnable, oErr, oAddress, oDataIn} !== {3'b110, 10'h005, 8'hA5}) begin
         nerr++;
         $display("FAIL wr_cmd: got ack/we/err=%b addr=%h din=%h, want 110 005 a5",
                  {oAckW, oWriteEnable, oErr}, oAddress, oDataIn);
      end
      reqW = 0;
      reqA = 1; addrA = 10'h005;
      tick();
      nvec++;
      if ({oAckA, oReadtoa, oWriteEnable, oAddress, oDataIn} !== {3'b110, 10'h005, 8'h00}) begin
         nerr++;
         $display("FAIL rd_cmd: got ack/rd/we=%b addr=%h din=%h, want 110 005 00",
                  {oAckA, oReadtoa, oWriteEnable}, oAddress, oDataIn);
      end
      reqA = 0;
      for (int i = 1; i <= RL; i++) begin
         tick();
         nvec++;
         if (oValidA !== (i == RL)) begin
            nerr++;
            $display("FAIL rd_valid_timing: %0d cycles after strobe got %b, want %b", i, oValidA, (i == RL));
         end
      end
      nvec++;
      if (oDataA !== 8'hA5) begin
         nerr++;
         $display("FAIL rd_data: got %h, want a5", oDataA);
      end
      idle(RL + 1);
   endtask

   task automatic test_three_way();
      logic [2:0] want;
      do_reset();
      reqW = 1; addrW = 10'h010; dataW = 8'h3C;
      reqA = 1; addrA = 10'h011;
      reqB = 1; addrB = 10'h012;
      for (int i = 0; i < 3; i++) begin
         tick();
         want = 3'b100 >> i;
         nvec++;
         if ({oAckW, oAckA, oAckB} !== want || {oWriteEnable, oReadtoa, oReadtob} !== want) begin
            nerr++;
            $display("FAIL three_way_order step %0d: acks %b strobes %b, want %b",
                     i, {oAckW, oAckA, oAckB}, {oWriteEnable, oReadtoa, oReadtob}, want);
         end
         if (oAckW) reqW = 0;
         if (oAckA) reqA = 0;
         if (oAckB) reqB = 0;
      end
      idle(RL + 1);
   endtask

   task automatic test_alternate();
      int prev = -1;
      int cur;
      reqA = 1; addrA = rnd_addr() % 16;
      reqB = 1; addrB = rnd_addr() % 16;
      for (int i = 0; i < 8; i++) begin
         tick();
         cur = oAckA ? 1 : (oAckB ? 2 : 0);
         nvec++;
         if (cur == 0 || (oAckA && oAckB) || cur == prev) begin
            nerr++;
            $display("FAIL alternate step %0d: ackA=%b ackB=%b prev=%0d, want single ack differing from prev",
                     i, oAckA, oAckB, prev);
         end
         prev = cur;
         if (oAckA) addrA = AW'($urandom_range(0, 15));
         if (oAckB) addrB = AW'($urandom_range(0, 15));
      end
      idle(RL + 1);
   endtask

   task automatic test_error();
      bit sawB = 0;
      reqB = 1; addrB = 10'h3FF;
      tick();
      nvec++;
      if ({oAckB, oErr, oReadtob} !== 3'b110) begin
         nerr++;
         $display("FAIL err_3ff: ack/err/rd=%b, want 110", {oAckB, oErr, oReadtob});
      end
      reqB = 0;
      reqA = 1; addrA = 10'd999;
      tick();
      nvec++;
      if ({oAckA, oErr, oReadtoa} !== 3'b101) begin
         nerr++;
         $display("FAIL err_999: ack/err/rd=%b, want 101", {oAckA, oErr, oReadtoa});
      end
      reqA = 0;
      reqW = 1; addrW = 10'd1000; dataW = 8'h77;
      tick();
      nvec++;
      if ({oAckW, oErr, oWriteEnable} !== 3'b110) begin
         nerr++;
         $display("FAIL err_1000: ack/err/we=%b, want 110", {oAckW, oErr, oWriteEnable});
      end
      reqW = 0;
      for (int i = 0; i < RL + 2; i++) begin
         tick();
         if (oValidB) sawB = 1;
      end
      nvec++;
      if (sawB) begin
         nerr++;
         $display("FAIL err_no_valid: oValidB pulsed=1, want 0");
      end
   endtask

   task automatic test_lone_writer();
      logic [DW-1:0] sent;
      idle(1);
      reqW = 1; addrW = AW'($urandom_range(0, 15)); dataW = DW'($urandom);
      for (int i = 0; i < 8; i++) begin
         sent = dataW;
         tick();
         nvec++;
         if (oAckW !== (i % 2 == 0) || oWriteEnable !== (i % 2 == 0)) begin
            nerr++;
            $display("FAIL lone_writer step %0d: ack=%b we=%b, want %b", i, oAckW, oWriteEnable, (i % 2 == 0));
         end
         if (oAckW) begin
            nvec++;
            if (oDataIn !== sent) begin
               nerr++;
               $display("FAIL lone_writer_data step %0d: got %h, want %h", i, oDataIn, sent);
            end
            addrW = AW'($urandom_range(0, 15));
            dataW = DW'($urandom);
         end
      end
      idle(RL + 1);
   endtask

   task automatic test_reset_mid_read();
      bit sawA = 0;
      reqA = 1; addrA = 10'h007;
      tick();
      nvec++;
      if (oReadtoa !== 1'b1) begin
         nerr++;
         $display("FAIL midrd_strobe: got %b, want 1", oReadtoa);
      end
      reqA = 0;
      #2 rst_n = 0;
      #1;
      nvec++;
      if ({oAckA, oValidA, oReadtoa, oErr, oAddress} !== '0) begin
         nerr++;
         $display("FAIL midrd_async_clear: got %b, want all zero", {oAckA, oValidA, oReadtoa, oErr, oAddress});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
      for (int i = 0; i < RL + 2; i++) begin
         tick();
         if (oValidA) sawA = 1;
      end
      nvec++;
      if (sawA) begin
         nerr++;
         $display("FAIL midrd_no_valid: oValidA pulsed=1, want 0");
      end
      reqA = 1; addrA = 10'h001;
      reqB = 1; addrB = 10'h002;
      tick();
      nvec++;
      if ({oAckA, oAckB} !== 2'b10) begin
         nerr++;
         $display("FAIL midrd_ptr_w: ackA/ackB=%b, want 10", {oAckA, oAckB});
      end
      idle(RL + 1);
   endtask

   task automatic test_random(int n);
      for (int i = 0; i < n; i++) begin
         tick();
         nvec++;
         if ({oAckW, oAckA, oAckB, oErr, oWriteEnable, oReadtoa, oReadtob, oValidA, oValidB} !==
             {e_ackW, e_ackA, e_ackB, e_err, e_we, e_ra, e_rb, e_vA, e_vB}) begin
            nerr++;
            $display("FAIL rnd_ctrl cyc %0d: got %b, want %b", cyc,
                     {oAckW, oAckA, oAckB, oErr, oWriteEnable, oReadtoa, oReadtob, oValidA, oValidB},
                     {e_ackW, e_ackA, e_ackB, e_err, e_we, e_ra, e_rb, e_vA, e_vB});
         end
         nvec++;
         if (oAddress !== e_addr || oDataIn !== e_din) begin
            nerr++;
            $display("FAIL rnd_bus cyc %0d: addr=%h din=%h, want addr=%h din=%h", cyc, oAddress, oDataIn, e_addr, e_din);
         end
         if (e_vA) begin
            nvec++;
            if (oDataA !== e_dA) begin
               nerr++;
               $display("FAIL rnd_dataA cyc %0d: got %h, want %h", cyc, oDataA, e_dA);
            end
         end
         if (e_vB) begin
            nvec++;
            if (oDataB !== e_dB) begin
               nerr++;
               $display("FAIL rnd_dataB cyc %0d: got %h, want %h", cyc, oDataB, e_dB);
            end
         end
         // Requesters hold until acked, then either re-request or drop.
         if (e_ackW) begin
            reqW = $urandom_range(0, 1); addrW = rnd_addr(); dataW = DW'($urandom);
         end else if (!reqW && $urandom_range(0, 2) == 0) begin
            reqW = 1; addrW = rnd_addr(); dataW = DW'($urandom);
         end
         if (e_ackA) begin
            reqA = $urandom_range(0, 1); addrA = rnd_addr();
         end else if (!reqA && $urandom_range(0, 2) == 0) begin
            reqA = 1; addrA = rnd_addr();
         end
         if (e_ackB) begin
            reqB = $urandom_range(0, 1); addrB = rnd_addr();
         end else if (!reqB && $urandom_range(0, 2) == 0) begin
            reqB = 1; addrB = rnd_addr();
         end
      end
      idle(RL + 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]   = DW'(i * 7 + 3);
         m_mem[i] = DW'(i * 7 + 3);
      end
      model_reset();
      test_reset();
      test_write_read();
      test_three_way();
      test_alternate();
      test_error();
      test_lone_writer();
      test_reset_mid_read();
      test_random(600);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
